mapping_scheduler: RTL and testbench
====================================

MAPPING_SCHEDULER -- requirements
Module: mapping_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: frame address width (N max 1024).
REQ-002 SHALL have parameter QLAG, default 2: cycles from readFrame rise to first Q slot.
REQ-003 SHALL have port clk  in  1: single clock, all logic on posedge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port enb  in  1: clock enable; when low, all state and outputs hold.
REQ-006 SHALL have port startIn  in  1: job start pulse.
REQ-007 SHALL have port nIn  in  8: log2 of code length N, legal 5..10.
REQ-008 SHALL have port kIn  in  ADDR_W: info-bit count K, legal 1..N.
REQ-009 SHALL have port dataIn  in  1: info bit.
REQ-010 SHALL have port dataValidIn  in  1: dataIn valid.
REQ-011 SHALL have port dataReadyOut  out  1: bit accepted when valid and ready.
REQ-012 SHALL have port maskAddr  out  ADDR_W: frozen/info mask address.
REQ-013 SHALL have port maskBit  in  1: mask bit, 1 = info position, valid 1 cycle after maskAddr.
REQ-014 SHALL have ports frameDIn out 1, frameWrAddr out ADDR_W, frameWrEn out 1: frame RAM write port.
REQ-015 SHALL have ports readFrame out 1, Q out 1, nOut out 8: drive the mapping datapath.
REQ-016 SHALL have ports busy out 1, doneOut out 1 (pulse), errOut out 1 (sticky).

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> READ -> DONE -> IDLE.
REQ-018 IDLE: startIn with legal nIn/kIn SHALL latch N=2^nIn, K, nOut=nIn, clear errOut, go LOAD.
REQ-019 IDLE: startIn with illegal nIn or kIn>N SHALL set errOut, stay IDLE.
REQ-020 startIn outside IDLE SHALL be ignored.
REQ-021 LOAD: dataReadyOut=1; each accepted bit SHALL be written next cycle: frameWrEn=1, frameDIn=bit, frameWrAddr=0,1,..,K-1.
REQ-022 After the K-th accept, dataReadyOut SHALL drop in the same cycle and FSM SHALL enter READ.
REQ-023 READ: readFrame SHALL be high for exactly N+QLAG cycles, rising on READ entry.
REQ-024 maskAddr SHALL sweep 0..N-1 at one per cycle, starting QLAG-1 cycles after readFrame rises.
REQ-025 Q SHALL equal registered maskBit, so Q slot i lands exactly QLAG+i cycles after readFrame rises; Q=0 outside the window.
REQ-026 An ADDR_W+1 bit counter SHALL count Q ones; count != K at window end SHALL set errOut.
REQ-027 DONE: doneOut SHALL pulse one cycle, then return to IDLE.
REQ-028 busy SHALL be 1 in all states except IDLE.
REQ-029 Counters SHALL compare against latched N/K; no wrap past N-1 or K-1.
REQ-030 dataValidIn while not ready SHALL be ignored; no bit is lost or duplicated.

Reset
REQ-031 Reset low SHALL immediately force IDLE, clear all counters, and drive every output to 0 (nOut=0, maskAddr=0).
REQ-032 Reset mid-job SHALL abort the job; no further frameWrEn or Q after release until a new startIn.

Structure
REQ-033 Package polar_map_pkg SHALL hold ADDR_W, NMAX=1024, nIn legal range 5..10, and the FSM state enum.
REQ-034 Sub-module mapping_slot_counter (loadable, enabled, terminal-count flag) SHALL be instantiated for load and read counters.

Verification
REQ-035 nIn=5, kIn=16, 16 bits back-to-back -> frameWrAddr 0..15, readFrame high 34 cycles, 16 Q ones, doneOut one pulse, errOut=0.
REQ-036 dataValidIn toggling 1/0 during LOAD -> exactly K writes, addresses contiguous.
REQ-037 nIn=4 or kIn=40 with nIn=5 -> errOut=1, busy stays 0.
REQ-038 Mask with 15 ones, kIn=16 -> errOut=1 after window, doneOut still pulses.
REQ-039 Reset asserted at READ slot 10 -> all outputs 0 at once; next startIn runs a clean job.
REQ-040 enb low 5 cycles mid-READ -> Q/readFrame timing stretched by exactly 5 cycles; second startIn during busy ignored.

Source files
------------

// File: rtl/polar_map_pkg.sv
// Shared constants and FSM state type for the polar-code mapping scheduler.
package polar_map_pkg;
    localparam int ADDR_W  = 10;
    localparam int NMAX    = 1024;
    localparam int NIN_MIN = 5;
    localparam int NIN_MAX = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mapping_scheduler_if.sv
// Data-in handshake, mask ROM, frame RAM write port and mapping-datapath drive.
interface mapping_scheduler_if #(
    parameter int ADDR_W = polar_map_pkg::ADDR_W
);
    logic              dataIn;
    logic              dataValidIn;
    logic              dataReadyOut;
    logic [ADDR_W-1:0] maskAddr;
    logic              maskBit;
    logic              frameDIn;
    logic [ADDR_W-1:0] frameWrAddr;
    logic              frameWrEn;
    logic              readFrame;
    logic              Q;
    logic [7:0]        nOut;

    modport master (
        input  dataIn, dataValidIn, maskBit,
        output dataReadyOut, maskAddr, frameDIn, frameWrAddr, frameWrEn,
               readFrame, Q, nOut
    );

    modport slave (
        output dataIn, dataValidIn, maskBit,
        input  dataReadyOut, maskAddr, frameDIn, frameWrAddr, frameWrEn,
               readFrame, Q, nOut
    );
endinterface

// File: rtl/mapping_slot_counter.sv
// Loadable up-counter that stops at term_val rather than wrapping past it.
module mapping_slot_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic         tc
);
    assign tc = (count == term_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enb) begin
            if (load) begin
                count <= load_val;
            end else if (inc && !tc) begin
                count <= count + W'(1);
            end
        end
    end
endmodule

// File: rtl/mapping_scheduler.sv
// Sequences one polar-mapping job: load K info bits into the frame RAM, then sweep
// the N-entry frozen/info mask to drive the mapping datapath and verify the info count.
module mapping_scheduler
    import polar_map_pkg::*;
#(
    parameter int ADDR_W = polar_map_pkg::ADDR_W,
    parameter int QLAG   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enb,
    input  logic               startIn,
    input  logic [7:0]         nIn,
    input  logic [ADDR_W-1:0]  kIn,
    output logic               busy,
    output logic               doneOut,
    output logic               errOut,
    mapping_scheduler_if.master bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAG_M1 = CW'(QLAG - 1);
    localparam logic [CW-1:0] LAG    = CW'(QLAG);

    state_t            state, state_nxt;
    logic [CW-1:0]     n_full, k_len, rd_term, rd_cnt, ones_cnt, ones_nxt;
    logic [ADDR_W-1:0] n_m1, k_m1, ld_cnt;
    logic              legal, start_ok, start_bad, accept;
    logic              ld_tc, rd_tc, rd_last, q_win;

    assign n_full = CW'(1) << nIn[3:0];
    assign legal  = (nIn >= 8'(NIN_MIN)) && (nIn <= 8'(NIN_MAX)) &&
                    (int'(nIn) <= ADDR_W) && (int'(n_full) <= NMAX) &&
                    (kIn != '0) && ({1'b0, kIn} <= n_full);

    assign start_ok  = (state == ST_IDLE) && startIn && legal;
    assign start_bad = (state == ST_IDLE) && startIn && !legal;

    // Ready is gated by enb so an upstream source never sees a handshake the
    // frozen pipeline would drop.
    assign bus.dataReadyOut = (state == ST_LOAD) && enb;
    assign accept           = bus.dataReadyOut && bus.dataValidIn;

    assign rd_last       = (state == ST_READ) && rd_tc;
    assign q_win         = (state == ST_READ) && (rd_cnt >= LAG);
    assign bus.readFrame = (state == ST_READ);
    assign bus.Q         = q_win & bus.maskBit;
    assign ones_nxt      = ones_cnt + CW'(bus.Q);

    assign busy    = (state != ST_IDLE);
    assign doneOut = (state == ST_DONE);

    mapping_slot_counter #(.W(ADDR_W)) u_load_cnt (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .load     (start_ok),
        .load_val ('0),
        .inc      (accept),
        .term_val (k_m1),
        .count    (ld_cnt),
        .tc       (ld_tc)
    );

    mapping_slot_counter #(.W(CW)) u_read_cnt (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .load     (start_ok),
        .load_val ('0),
        .inc      (state == ST_READ),
        .term_val (rd_term),
        .count    (rd_cnt),
        .tc       (rd_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (enb) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_LOAD;
            ST_LOAD: if (accept && ld_tc) state_nxt = ST_READ;
            ST_READ: if (rd_tc) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_m1            <= '0;
            k_m1            <= '0;
            k_len           <= '0;
            rd_term         <= '0;
            ones_cnt        <= '0;
            errOut          <= 1'b0;
            bus.nOut        <= '0;
            bus.frameWrEn   <= 1'b0;
            bus.frameDIn    <= 1'b0;
            bus.frameWrAddr <= '0;
            bus.maskAddr    <= '0;
        end else if (enb) begin
            bus.frameWrEn <= accept;
            if (accept) begin
                bus.frameDIn    <= bus.dataIn;
                bus.frameWrAddr <= ld_cnt;
            end

            if (start_ok) begin
                n_m1     <= ADDR_W'(n_full - CW'(1));
                k_m1     <= kIn - ADDR_W'(1);
                k_len    <= {1'b0, kIn};
                rd_term  <= n_full + LAG_M1;
                ones_cnt <= '0;
                bus.nOut <= nIn;
                errOut   <= 1'b0;
            end else if (start_bad) begin
                errOut <= 1'b1;
            end

            if (bus.Q) begin
                ones_cnt <= ones_nxt;
            end
            if (rd_last && (ones_nxt != k_len)) begin
                errOut <= 1'b1;
            end

            // Mask address leads Q by one cycle to cover the ROM read latency.
            if (state != ST_READ) begin
                bus.maskAddr <= '0;
            end else if ((rd_cnt >= LAG_M1) && (bus.maskAddr != n_m1)) begin
                bus.maskAddr <= bus.maskAddr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mapping_scheduler.sv
// Directed, table-driven bench for mapping_scheduler with a mask ROM and frame-write monitor.
module tb_mapping_scheduler;
    localparam int ADDR_W = 10;
    localparam int QLAG   = 2;

    typedef struct {
        int n_in;
        int k_in;
        int mask_ones;
        int toggle;
        int stall_at;
        int exp_err;
        int exp_writes;
        int exp_rf;
        int exp_qones;
        int exp_done;
    } vec_t;

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              enb     = 1'b0;
    logic              startIn = 1'b0;
    logic [7:0]        nIn     = '0;
    logic [ADDR_W-1:0] kIn     = '0;
    logic              busy, doneOut, errOut;

    logic mask_mem [0:1023];
    logic bits     [0:1023];
    int   checks = 0;
    int   errors = 0;

    mapping_scheduler_if #(.ADDR_W(ADDR_W)) bus();

    mapping_scheduler #(.ADDR_W(ADDR_W), .QLAG(QLAG)) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .startIn (startIn),
        .nIn     (nIn),
        .kIn     (kIn),
        .busy    (busy),
        .doneOut (doneOut),
        .errOut  (errOut),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Mask ROM: one-cycle read latency, frozen together with the scheduler.
    always @(posedge clk) if (enb) bus.maskBit <= mask_mem[bus.maskAddr];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic run_job(input int idx, input vec_t v, input int abort_at);
        int n_len, cnt, bit_idx, te, e0, rel, rf_cnt, q_ones, t_bad;
        int wr_cnt, wr_bad, done_cnt, busy_cnt, stall_left;
        bit prev_enb, seen_rf, stall_started, finished, exp_rf, exp_q;
        n_len = (v.n_in >= 0 && v.n_in <= 10) ? (1 << v.n_in) : 0;
        for (int i = 0; i < 1024; i++) begin
            mask_mem[i] = 1'b0;
            bits[i]     = (((i * 5) + 1) % 3) == 0;
        end
        cnt = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 1 - p; i < n_len; i += 2)
                if (cnt < v.mask_ones) begin
                    mask_mem[i] = 1'b1;
                    cnt++;
                end
        bit_idx = 0; te = 0; e0 = 0; rf_cnt = 0; q_ones = 0; t_bad = 0;
        wr_cnt = 0; wr_bad = 0; done_cnt = 0; busy_cnt = 0; stall_left = 0;
        seen_rf = 0; stall_started = 0; finished = 0;

        @(negedge clk);
        startIn = 1'b1;
        nIn = 8'(v.n_in);
        kIn = ADDR_W'(v.k_in);
        enb = 1'b1;
        bus.dataValidIn = 1'b0;
        prev_enb = 1'b1;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (prev_enb) te++;
            if (bus.readFrame && !seen_rf) begin
                seen_rf = 1;
                e0 = te;
            end
            rel    = te - e0;
            exp_rf = seen_rf && (rel < n_len + QLAG);
            exp_q  = 1'b0;
            if (seen_rf && rel >= QLAG && rel < n_len + QLAG) exp_q = mask_mem[rel - QLAG];
            if (bus.readFrame !== exp_rf || bus.Q !== exp_q) t_bad++;
            if (bus.readFrame) rf_cnt++;
            if (bus.Q && prev_enb) q_ones++;
            if (doneOut && prev_enb) done_cnt++;
            if (busy) busy_cnt++;
            if (abort_at >= 0 && seen_rf && rel == QLAG + abort_at) return;
            if (done_cnt > 0 && !busy) finished = 1;
            if (v.exp_done == 0 && cyc >= 10) finished = 1;

            // A second start while busy must be ignored.
            startIn = bus.readFrame && (rf_cnt == 3);
            if (startIn) begin
                nIn = 8'(v.n_in + 1);
                kIn = ADDR_W'(3);
            end
            if (v.stall_at >= 0 && !stall_started && rf_cnt == v.stall_at) begin
                stall_started = 1;
                stall_left = 5;
            end
            enb = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            bus.dataValidIn = v.toggle != 0 ? (cyc % 2 == 0) : 1'b1;
            bus.dataIn = bits[bit_idx < 1023 ? bit_idx : 1023];
            #1;
            if (bus.dataValidIn && bus.dataReadyOut) bit_idx++;
            if (bus.frameWrEn && enb) begin
                if (wr_cnt > 1023 || int'(bus.frameWrAddr) != wr_cnt ||
                    bus.frameDIn !== bits[wr_cnt > 1023 ? 1023 : wr_cnt]) wr_bad++;
                wr_cnt++;
            end
            prev_enb = enb;
        end
        startIn = 1'b0;
        bus.dataValidIn = 1'b0;
        check($sformatf("v%0d_finished", idx), int'(finished), 1);
        check($sformatf("v%0d_err", idx), int'(errOut), v.exp_err);
        check($sformatf("v%0d_writes", idx), wr_cnt, v.exp_writes);
        check($sformatf("v%0d_wr_addr_data", idx), wr_bad, 0);
        check($sformatf("v%0d_readframe_cycles", idx), rf_cnt, v.exp_rf);
        check($sformatf("v%0d_q_ones", idx), q_ones, v.exp_qones);
        check($sformatf("v%0d_q_timing", idx), t_bad, 0);
        check($sformatf("v%0d_done_pulses", idx), done_cnt, v.exp_done);
        if (v.exp_done != 0) check($sformatf("v%0d_nout", idx), int'(bus.nOut), v.n_in);
        else check($sformatf("v%0d_busy_cycles", idx), busy_cnt, 0);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t base;
        int act;
        //          n   k   ones tog stall err wr  rf  q   done
        vecs[0] = '{5,  16, 16,  0,  -1,   0,  16, 34, 16, 1};
        vecs[1] = '{5,  16, 16,  1,  -1,   0,  16, 34, 16, 1};
        vecs[2] = '{4,  8,  8,   0,  -1,   1,  0,  0,  0,  0};
        vecs[3] = '{5,  1,  1,   0,  -1,   0,  1,  34, 1,  1};
        vecs[4] = '{5,  40, 16,  0,  -1,   1,  0,  0,  0,  0};
        vecs[5] = '{5,  16, 15,  0,  -1,   1,  16, 34, 15, 1};
        vecs[6] = '{6,  20, 20,  0,  10,   0,  20, 71, 20, 1};
        vecs[7] = '{11, 5,  5,   0,  -1,   1,  0,  0,  0,  0};
        vecs[8] = '{7,  100,100, 1,  -1,   0,  100,130,100,1};
        vecs[9] = '{5,  0,  0,   0,  -1,   1,  0,  0,  0,  0};
        base = vecs[0];

        bus.dataIn = 1'b0;
        bus.dataValidIn = 1'b0;
        for (int i = 0; i < 1024; i++) mask_mem[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(doneOut), 0);
        check("rst_err", int'(errOut), 0);
        check("rst_ready", int'(bus.dataReadyOut), 0);
        check("rst_readframe", int'(bus.readFrame), 0);
        check("rst_q", int'(bus.Q), 0);
        check("rst_nout", int'(bus.nOut), 0);
        check("rst_maskaddr", int'(bus.maskAddr), 0);
        check("rst_wren", int'(bus.frameWrEn), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_job(i, vecs[i], -1);

        // Abort in the middle of the Q window, then confirm a clean restart.
        run_job(20, base, 10);
        check("pre_abort_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_readframe", int'(bus.readFrame), 0);
        check("abort_q", int'(bus.Q), 0);
        check("abort_nout", int'(bus.nOut), 0);
        check("abort_maskaddr", int'(bus.maskAddr), 0);
        check("abort_wren", int'(bus.frameWrEn), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        enb = 1'b1;
        bus.dataValidIn = 1'b1;
        act = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.frameWrEn || bus.Q || bus.readFrame || busy || doneOut) act++;
        end
        check("post_abort_activity", act, 0);
        bus.dataValidIn = 1'b0;
        run_job(21, base, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
